alu_src_b_stage: RTL and testbench
==================================

// Module: alu_src_b_stage
// PURPOSE
//  Registered, parametrised successor to the ALU B-operand selector of the multicycle datapath.
//  Builds the B operand from the B register, the PC increment constant or the 16-bit immediate.
//  The immediate can be sign-extended, shifted, zero-extended, LUI-placed or used as shamt.
//  Output goes through a 2-entry valid/ready buffer so the ALU can stall without losing operands.
//  Sits between the register file/IR outputs and the ALU B input.
// PARAMETERS
//  DATA_W   32  operand width (>= IMM_W+2)
//  IMM_W    16  immediate field width taken from the IR
//  SEL_W     4  selector width; codes >= 8 are illegal
//  PC_INC    4  constant driven for selector 1
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       sel/b_in/imm valid this cycle
//  in_ready   out  1       stage can accept a new operand
//  sel        in   SEL_W   source select (see BEHAVIOUR)
//  b_in       in   DATA_W  B register value
//  imm        in   IMM_W   IR immediate field
//  out_valid  out  1       out_data holds a valid operand
//  out_ready  in   1       ALU consumes out_data this cycle
//  out_data   out  DATA_W  selected operand (head of buffer)
//  illegal    out  1       sticky: an illegal sel was accepted
// BEHAVIOUR
//  Selector map (SE = sign-extend imm to DATA_W, ZE = zero-extend):
//   0 b_in | 1 PC_INC | 2 SE(imm) | 3 SE(imm)<<2 (low 2 bits 0) | 4 ZE(imm)
//   5 imm<<(DATA_W-IMM_W), low bits 0 | 6 ZE(imm[10:6]) (shamt) | 7 all zero
//   8..2^SEL_W-1: operand = 0 and illegal sets to 1 on acceptance
//  Shifts are logical and truncated to DATA_W; no bits carry out.
//  Accept = in_valid & in_ready; operand computed combinationally and written on that edge.
//  Transfer = out_valid & out_ready; head entry is popped on that edge.
//  Buffer is a 2-entry FIFO with count in {0,1,2}.
//  in_ready = (count != 2), combinational from the count register only.
//  out_valid = (count != 0); out_data = head entry, registered, no combinational path from inputs.
//  Latency: an operand accepted at edge k is visible on out_data after edge k; minimum 1 cycle.
//  Throughput: 1 operand/cycle while out_ready is held high.
//  Count transitions: accept only +1; transfer only -1; accept & transfer = unchanged.
//  When count==1 and both occur, the new entry becomes the head at the next cycle.
//  Full (count==2): in_ready=0, so in_valid is ignored and no inputs are sampled.
//  Empty (count==0): out_ready is ignored.
//  Order is strictly FIFO; the head is stable while out_valid=1 and out_ready=0.
//  illegal is cleared only by reset, and stays set even if the illegal entry is consumed.
//  Reset (any cycle, including mid-transfer) sets count=0, out_valid=0, out_data=0 and illegal=0.
//  in_ready=1 from the first cycle after reset; buffered entries are discarded.
// TESTING
//  1 reset high 2 cycles -> out_valid=0, out_data=0, in_ready=1, illegal=0.
//  2 out_ready=1, one op per cycle -> next cycle out_data matches, 1/cycle:
//    sel=0 b_in=0x12345678 -> 0x12345678; sel=1 -> 0x00000004
//    sel=2 imm=0x8001 -> 0xFFFF8001; sel=3 imm=0xFFFF -> 0xFFFFFFFC
//    sel=4 imm=0x8001 -> 0x00008001; sel=5 imm=0x1234 -> 0x12340000
//    sel=6 imm=0x07C0 -> 0x0000001F
//  3 out_ready=0, 3 ops offered (sel=1, 2/imm=5, 0/b_in=7) -> 2 accepted, in_ready=0
//    then out_ready=1 -> 4, 5 in order, then the third is accepted and output as 7.
//  4 count==1 with accept and transfer on the same edge -> count stays 1 and new data is at the head.
//  5 sel=9 accepted -> out_data=0, illegal=1; illegal stays 1 after further legal ops until reset.
//  6 count==2, reset asserted mid-stream -> next cycle out_valid=0, in_ready=1, old data never appears.

Source files
------------

// File: rtl/alu_src_b_stage.sv
// ALU B-operand source selector with a 2-entry valid/ready output buffer.
// Operands are built from the B register, the PC increment or the IR immediate.
module alu_src_b_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SEL_W  = 4,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] b_in,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              illegal
);

    localparam int EXT_W = DATA_W - IMM_W;

    function automatic logic [DATA_W-1:0] build_operand(
        input logic [SEL_W-1:0]  s,
        input logic [DATA_W-1:0] b,
        input logic [IMM_W-1:0]  im
    );
        logic [DATA_W-1:0] se_s;
        logic [DATA_W-1:0] ze_s;
        logic [DATA_W-1:0] res_s;
        se_s = {{EXT_W{im[IMM_W-1]}}, im};
        ze_s = {{EXT_W{1'b0}}, im};
        if (s >= SEL_W'(8)) begin
            res_s = {DATA_W{1'b0}};
        end else begin
            case (s[2:0])
                3'd0:    res_s = b;
                3'd1:    res_s = DATA_W'(PC_INC);
                3'd2:    res_s = se_s;
                3'd3:    res_s = {se_s[DATA_W-3:0], 2'b00};
                3'd4:    res_s = ze_s;
                3'd5:    res_s = {im, {EXT_W{1'b0}}};
                3'd6:    res_s = {{(DATA_W-5){1'b0}}, im[10:6]};
                3'd7:    res_s = {DATA_W{1'b0}};
                default: res_s = {DATA_W{1'b0}};
            endcase
        end
        return res_s;
    endfunction

    logic [1:0]        count_r;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic              illegal_r;
    logic [DATA_W-1:0] operand_s;
    logic              sel_illegal_s;
    logic              accept_s;
    logic              transfer_s;

    // Operand selection and handshake decode.
    always_comb begin
        operand_s     = build_operand(sel, b_in, imm);
        sel_illegal_s = (sel >= SEL_W'(8));
        accept_s      = in_valid & in_ready;
        transfer_s    = out_valid & out_ready;
    end

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign illegal   = illegal_r;

    // Buffer state: head_r is the oldest entry, tail_r only holds data when count is 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= 2'd0;
            head_r    <= {DATA_W{1'b0}};
            tail_r    <= {DATA_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            case ({accept_s, transfer_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= operand_s;
                    end else begin
                        tail_r <= operand_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                // Both handshakes only coincide at count 1: the new entry replaces the head.
                2'b11: begin
                    head_r <= operand_s;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
            if (accept_s && sel_illegal_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Scenario-driven bench for alu_src_b_stage; a monitor scores every transfer
// against a queue of expected operands pushed at acceptance.
module tb_alu_src_b_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] b_in;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        illegal;

    int          total;
    int          bad;
    logic [31:0] sb[$];

    alu_src_b_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .b_in      (b_in),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] s, input logic [31:0] b, input logic [15:0] im);
        logic [31:0] sx;
        sx = 32'($signed(im));
        case (s)
            4'd0:    return b;
            4'd1:    return 32'd4;
            4'd2:    return sx;
            4'd3:    return sx * 32'd4;
            4'd4:    return 32'(im);
            4'd5:    return 32'(im) * 32'd65536;
            4'd6:    return (32'(im) >> 6) & 32'h1F;
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard monitor: samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: out_data=%h with no operand pending", out_data);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %h expected %h", out_data, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(sel, b_in, imm));
        end
    end

    task automatic step(input logic v, input logic [3:0] s, input logic [31:0] b,
                        input logic [15:0] im, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        b_in      = b;
        imm       = im;
        out_ready = ordy;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        settle();
        settle();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ov=%b od=%h ir=%b ill=%b expected 0 0 1 0",
                     out_valid, out_data, in_ready, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_selectors();
        logic [3:0]  s_t[7]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [15:0] im_t[7] = '{16'h0000, 16'h0000, 16'h8001, 16'hFFFF, 16'h8001, 16'h1234, 16'h07C0};
        logic [31:0] ex_t[7] = '{32'h12345678, 32'h00000004, 32'hFFFF8001, 32'hFFFFFFFC,
                                 32'h00008001, 32'h12340000, 32'h0000001F};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s_t[i], 32'h12345678, im_t[i], 1'b1);
            settle();
            total++;
            if (out_valid !== 1'b1 || out_data !== ex_t[i]) begin
                bad++;
                $display("FAIL sel_%0d: ov=%b od=%h expected 1 %h", s_t[i], out_valid, out_data, ex_t[i]);
            end
        end
        step(1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        settle();
        chk("sel_drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic test_backpressure();
        step(1'b1, 4'd1, 32'd0, 16'd0, 1'b0);
        settle();
        chk("bp_head_first", out_data, 32'd4);
        step(1'b1, 4'd2, 32'd0, 16'd5, 1'b0);
        settle();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        step(1'b1, 4'd0, 32'd7, 16'd0, 1'b0);
        settle();
        chk("bp_head_stable", out_data, 32'd4);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        step(1'b1, 4'd0, 32'd7, 16'd0, 1'b1);
        settle();
        chk("bp_second", out_data, 32'd5);
        step(1'b1, 4'd0, 32'd7, 16'd0, 1'b1);
        settle();
        chk("bp_third", out_data, 32'd7);
        step(1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        settle();
        chk("bp_empty", 32'(out_valid), 32'd0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'd0, 32'hAAAA0001, 16'd0, 1'b0);
        settle();
        step(1'b1, 4'd0, 32'hBBBB0002, 16'd0, 1'b1);
        settle();
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'hBBBB0002) begin
            bad++;
            $display("FAIL b2b_count1: ov=%b ir=%b od=%h expected 1 1 bbbb0002", out_valid, in_ready, out_data);
        end
        step(1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        settle();
        chk("b2b_drain", 32'(out_valid), 32'd0);
    endtask

    task automatic test_illegal();
        step(1'b1, 4'd9, 32'hDEADBEEF, 16'hFFFF, 1'b1);
        settle();
        chk("ill_data", out_data, 32'd0);
        chk("ill_flag", 32'(illegal), 32'd1);
        step(1'b1, 4'd0, 32'h00000055, 16'd0, 1'b1);
        settle();
        chk("ill_sticky", 32'(illegal), 32'd1);
        step(1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        settle();
        chk("ill_sticky_idle", 32'(illegal), 32'd1);
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 4'd0, 32'h00000111, 16'd0, 1'b0);
        step(1'b1, 4'd0, 32'h00000222, 16'd0, 1'b0);
        settle();
        chk("rst_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        settle();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: ov=%b ir=%b od=%h ill=%b expected 0 1 0 0",
                     out_valid, in_ready, out_data, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_no_old", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), $urandom,
                 16'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        settle();
        chk("stream_drained", 32'(sb.size()), 32'd0);
        chk("stream_no_illegal", 32'(illegal), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        sel = 4'd0;
        b_in = 32'd0;
        imm = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_selectors();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_midstream();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
